mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied IM-request cycles before IM gets priority.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 8: maximum in-flight loads per requester.
REQ-003 SHALL have these ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- im_command  in  2  IF request; BUS_NONE or BUS_LOAD only.
- im_addr  in  32  IF address.
- im_gnt  out  1  IF request accepted this cycle.
- im_rsp_valid  out  1  IF load data valid this cycle.
- im_rsp_data  out  32  IF load data.
- dm_command  in  2  MEM-stage request; BUS_NONE, BUS_LOAD or BUS_STORE.
- dm_addr  in  32  MEM-stage address.
- dm_wdata  in  32  MEM-stage store data.
- dm_gnt  out  1  DM request accepted this cycle.
- dm_rsp_valid  out  1  DM load data valid this cycle.
- dm_rsp_data  out  32  DM load data.
- proc2mem_command  out  2  command to the shared mem.
- proc2mem_addr  out  32  address to mem.
- proc2mem_data  out  32  store data to mem.
- mem2proc_response  in  4  nonzero tag = accepted; 0 = rejected.
- mem2proc_data  in  32  returned load data.
- mem2proc_tag  in  4  nonzero = data for that tag is valid this cycle.
- tag_err  out  1  sticky: a tag returned with no matching entry.

Function
REQ-004 SHALL drive the winning requester's command, address and data onto proc2mem_* combinationally in the same cycle. If no requester is eligible, it SHALL drive BUS_NONE.
REQ-005 SHALL consider a requester eligible when its command is not BUS_NONE and, for a load, its outstanding count is below MAX_OUTSTANDING.
REQ-006 SHALL use a priority FSM with states PRI_DM (reset state) and PRI_IM:
- In PRI_DM, DM wins when eligible.
- In PRI_IM, IM wins when eligible.
REQ-007 SHALL keep a starve counter:
- Increments each cycle IM is eligible but not granted.
- Clears on an IM grant or when IM is not eligible.
- PRI_DM→PRI_IM when the counter reaches STARVE_LIMIT.
- PRI_IM→PRI_DM after an IM grant or when IM is not eligible.
REQ-008 SHALL assert the winner's gnt only when mem2proc_response≠0. If the response is 0, no gnt is asserted, no state changes except the starve counter, and the requester retries.
REQ-009 SHALL, on a granted load, record entry[mem2proc_response] = {valid, owner} in a 15-entry tag table (tags 1..15) and increment that owner's outstanding count.
REQ-010 SHALL create no table entry for a granted store.
REQ-011 SHALL handle a returned tag (mem2proc_tag≠0) with a valid entry as follows, zero latency:
- Assert the owner's rsp_valid for that cycle with rsp_data = mem2proc_data.
- Clear the entry.
- Decrement the owner's count.
REQ-012 SHALL, when mem2proc_tag≠0 has no valid entry, assert no rsp_valid and set tag_err until reset.
REQ-013 SHALL process a same-cycle return and new grant of the same tag return-first, leaving the entry valid for the new owner. A same-cycle increment and decrement of one count SHALL leave the count unchanged.
REQ-014 SHALL never assert im_rsp_valid and dm_rsp_valid in the same cycle.

Reset
REQ-015 SHALL, while rst=0, immediately:
- Clear the tag table, both outstanding counts, the starve counter and tag_err.
- Set the FSM to PRI_DM.
- Force proc2mem_command=BUS_NONE, both gnt=0, both rsp_valid=0, and both rsp_data=0.
REQ-016 SHALL discard all in-flight loads on reset mid-operation. Tags returned after reset release SHALL set tag_err.

Structure
REQ-017 SHALL take the BUS_NONE/BUS_LOAD/BUS_STORE encodings, the arbiter-state enum and the owner encoding (OWN_IM=0, OWN_DM=1) from sys_defs.vh.
REQ-018 SHALL implement the tag table, outstanding counts and tag_err in sub-module mem_arb_tag_table; arbitration and the FSM SHALL stay in mem_arbiter.

Verification
REQ-019 SHALL cover these directed scenarios:
- Both request loads at 0x100 (IM) and 0x200 (DM), response=3 → dm_gnt=1, im_gnt=0, proc2mem_addr=0x200; tag 3 returns 0xDEADBEEF → dm_rsp_valid=1, dm_rsp_data=0xDEADBEEF.
- DM requests continuously, IM continuously, STARVE_LIMIT=4 → im_gnt=1 on the 5th contended accepted cycle, then DM priority returns.
- DM store 0x55 to 0x40, response=2 → dm_gnt=1; later mem2proc_tag=2 → no rsp_valid, tag_err=1.
- IM issues 8 loads with none returned → 9th IM request sees im_gnt=0 and DM is granted; one return → IM granted next.
- Tag 5 returns while IM is granted new tag 5 in the same cycle → IM rsp_valid=1 and entry 5 stays valid for IM.
- rst=0 asserted with 3 loads outstanding → all outputs zero/BUS_NONE immediately; after release, a stale tag return sets tag_err=1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared bus encodings, arbiter state, owner ids and tag-table entry type
// for the IF/MEM memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } bus_cmd_e;

  typedef enum logic {
    PRI_DM = 1'b0,
    PRI_IM = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IM = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int TAG_W    = 4;
  localparam int NUM_TAGS = 16;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_entry_t;

  function automatic logic is_load(input logic [1:0] cmd);
    return cmd == BUS_LOAD;
  endfunction

endpackage

// File: rtl/mem_arb_tag_table.sv
// Outstanding-load tracker: tag -> owner table, per-owner in-flight counts,
// zero-latency response steering and sticky unknown-tag error.
module mem_arb_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alloc_i,
  input  owner_e           alloc_owner_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  input  logic [TAG_W-1:0] ret_tag_i,
  input  logic [31:0]      ret_data_i,
  output logic             im_full_o,
  output logic             dm_full_o,
  output logic             im_rsp_valid_o,
  output logic [31:0]      im_rsp_data_o,
  output logic             dm_rsp_valid_o,
  output logic [31:0]      dm_rsp_data_o,
  output logic             tag_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  tag_entry_t [NUM_TAGS-1:0] tbl_q, tbl_d;
  logic [CNT_W-1:0] im_cnt_q, im_cnt_d;
  logic [CNT_W-1:0] dm_cnt_q, dm_cnt_d;
  logic tag_err_q, tag_err_d;

  logic ret_any, hit, im_ret, dm_ret;
  logic im_alloc, dm_alloc;

  assign ret_any  = ret_tag_i != '0;
  assign hit      = ret_any && tbl_q[ret_tag_i].valid;
  assign im_ret   = hit && (tbl_q[ret_tag_i].owner == OWN_IM);
  assign dm_ret   = hit && (tbl_q[ret_tag_i].owner == OWN_DM);
  assign im_alloc = alloc_i && (alloc_owner_i == OWN_IM);
  assign dm_alloc = alloc_i && (alloc_owner_i == OWN_DM);

  // Return is applied before allocation so a recycled tag ends up owned
  // by the new requester.
  always_comb begin
    tbl_d     = tbl_q;
    tag_err_d = tag_err_q;
    if (ret_any && !hit) tag_err_d = 1'b1;
    if (hit) tbl_d[ret_tag_i] = '0;
    if (alloc_i) begin
      tbl_d[alloc_tag_i].valid = 1'b1;
      tbl_d[alloc_tag_i].owner = alloc_owner_i;
    end
    im_cnt_d = im_cnt_q + CNT_W'(im_alloc) - CNT_W'(im_ret);
    dm_cnt_d = dm_cnt_q + CNT_W'(dm_alloc) - CNT_W'(dm_ret);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_q     <= '0;
      im_cnt_q  <= '0;
      dm_cnt_q  <= '0;
      tag_err_q <= 1'b0;
    end else begin
      tbl_q     <= tbl_d;
      im_cnt_q  <= im_cnt_d;
      dm_cnt_q  <= dm_cnt_d;
      tag_err_q <= tag_err_d;
    end
  end

  assign im_full_o = im_cnt_q >= CNT_W'(MAX_OUTSTANDING);
  assign dm_full_o = dm_cnt_q >= CNT_W'(MAX_OUTSTANDING);

  assign im_rsp_valid_o = rst_ni && im_ret;
  assign dm_rsp_valid_o = rst_ni && dm_ret;
  assign im_rsp_data_o  = im_rsp_valid_o ? ret_data_i : '0;
  assign dm_rsp_data_o  = dm_rsp_valid_o ? ret_data_i : '0;
  assign tag_err_o      = tag_err_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IF/MEM) arbiter onto a single tagged memory port with
// DM-first priority and an IM anti-starvation override.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  im_command,
  input  logic [31:0] im_addr,
  output logic        im_gnt,
  output logic        im_rsp_valid,
  output logic [31:0] im_rsp_data,
  input  logic [1:0]  dm_command,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rsp_valid,
  output logic [31:0] dm_rsp_data,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [31:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [31:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic        tag_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state_q;
  logic [SW-1:0] starve_q, starve_d;

  logic im_full, dm_full;
  logic im_elig, dm_elig;
  logic win_im, win_dm;
  logic accept, hold;
  logic alloc;
  owner_e alloc_owner;

  assign im_elig = (im_command != BUS_NONE) &&
                   !(is_load(im_command) && im_full);
  assign dm_elig = (dm_command != BUS_NONE) &&
                   !(is_load(dm_command) && dm_full);

  assign win_im = im_elig && (state_q == PRI_IM || !dm_elig);
  assign win_dm = dm_elig && !win_im;

  assign accept = mem2proc_response != '0;
  assign im_gnt = rst && win_im && accept;
  assign dm_gnt = rst && win_dm && accept;

  // A rejected winner freezes the FSM; only the starve count moves.
  assign hold = (win_im || win_dm) && !accept;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    unique case (1'b1)
      rst && win_im: begin
        proc2mem_command = im_command;
        proc2mem_addr    = im_addr;
      end
      rst && win_dm: begin
        proc2mem_command = dm_command;
        proc2mem_addr    = dm_addr;
        proc2mem_data    = dm_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = '0;
    if (im_elig && !im_gnt)
      starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PRI_DM;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (!hold) begin
        unique case (state_q)
          PRI_DM: if (starve_d >= SW'(STARVE_LIMIT)) state_q <= PRI_IM;
          PRI_IM: if (im_gnt || !im_elig) state_q <= PRI_DM;
          default: state_q <= PRI_DM;
        endcase
      end
    end
  end

  assign alloc = (im_gnt && is_load(im_command)) ||
                 (dm_gnt && is_load(dm_command));
  assign alloc_owner = dm_gnt ? OWN_DM : OWN_IM;

  mem_arb_tag_table #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_tag_table (
    .clk_i          (clk),
    .rst_ni         (rst),
    .alloc_i        (alloc),
    .alloc_owner_i  (alloc_owner),
    .alloc_tag_i    (mem2proc_response),
    .ret_tag_i      (mem2proc_tag),
    .ret_data_i     (mem2proc_data),
    .im_full_o      (im_full),
    .dm_full_o      (dm_full),
    .im_rsp_valid_o (im_rsp_valid),
    .im_rsp_data_o  (im_rsp_data),
    .dm_rsp_valid_o (dm_rsp_valid),
    .dm_rsp_data_o  (dm_rsp_data),
    .tag_err_o      (tag_err)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 4;
  localparam int MAXO  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  im_command = 2'd0;
  logic [31:0] im_addr = '0;
  logic        im_gnt, im_rsp_valid;
  logic [31:0] im_rsp_data;
  logic [1:0]  dm_command = 2'd0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_gnt, dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr, proc2mem_data;
  logic [3:0]  mem2proc_response = '0;
  logic [31:0] mem2proc_data = '0;
  logic [3:0]  mem2proc_tag = '0;
  logic        tag_err;

  int checks = 0;
  int errors = 0;

  // Model: which tags are in flight and for whom, per-owner counts,
  // how long IM has waited, whether IM currently holds priority.
  bit mv[16];
  bit mo_dm[16];
  int icnt, dcnt, starve;
  bit pri_im, merr;

  always #5 clk = ~clk;

  mem_arbiter #(
    .STARVE_LIMIT(LIMIT),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .im_command        (im_command),
    .im_addr           (im_addr),
    .im_gnt            (im_gnt),
    .im_rsp_valid      (im_rsp_valid),
    .im_rsp_data       (im_rsp_data),
    .dm_command        (dm_command),
    .dm_addr           (dm_addr),
    .dm_wdata          (dm_wdata),
    .dm_gnt            (dm_gnt),
    .dm_rsp_valid      (dm_rsp_valid),
    .dm_rsp_data       (dm_rsp_data),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .tag_err           (tag_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int t = 0; t < 16; t++) begin
      mv[t] = 1'b0;
      mo_dm[t] = 1'b0;
    end
    icnt = 0; dcnt = 0; starve = 0; pri_im = 1'b0; merr = 1'b0;
  endtask

  always @(negedge clk) begin : cmp
    bit ie, de, wi, wd, acc, ig, dg, irv, drv;
    logic [1:0] ec;
    logic [31:0] ea, ed;
    if (!rst) begin
      model_clear();
      chk("rst_cmd", proc2mem_command, BUS_NONE);
      chk("rst_gnt", {im_gnt, dm_gnt}, 0);
      chk("rst_rsp", {im_rsp_valid, dm_rsp_valid}, 0);
      chk("rst_err", tag_err, 0);
    end else begin
      ie = im_command != BUS_NONE &&
           (im_command != BUS_LOAD || icnt < MAXO);
      de = dm_command != BUS_NONE &&
           (dm_command != BUS_LOAD || dcnt < MAXO);
      if (pri_im) begin
        wi = ie; wd = !ie && de;
      end else begin
        wd = de; wi = !de && ie;
      end
      acc = mem2proc_response != 0;
      ig = wi && acc;
      dg = wd && acc;
      ec = wi ? im_command : wd ? dm_command : BUS_NONE;
      ea = wi ? im_addr : wd ? dm_addr : 32'h0;
      ed = wd ? dm_wdata : 32'h0;
      irv = mem2proc_tag != 0 && mv[mem2proc_tag] && !mo_dm[mem2proc_tag];
      drv = mem2proc_tag != 0 && mv[mem2proc_tag] && mo_dm[mem2proc_tag];
      chk("cmd", proc2mem_command, ec);
      if (ec != BUS_NONE) begin
        chk("addr", proc2mem_addr, ea);
        if (wd) chk("wdata", proc2mem_data, ed);
      end
      chk("im_gnt", im_gnt, ig);
      chk("dm_gnt", dm_gnt, dg);
      chk("im_rsp_valid", im_rsp_valid, irv);
      chk("dm_rsp_valid", dm_rsp_valid, drv);
      if (irv) chk("im_rsp_data", im_rsp_data, mem2proc_data);
      if (drv) chk("dm_rsp_data", dm_rsp_data, mem2proc_data);
      chk("tag_err", tag_err, merr);
      if (ie && !ig) starve++;
      else starve = 0;
      if (!((wi || wd) && !acc)) begin
        if (!pri_im && starve >= LIMIT) pri_im = 1'b1;
        else if (pri_im && (ig || !ie)) pri_im = 1'b0;
      end
      if (mem2proc_tag != 0) begin
        if (mv[mem2proc_tag]) begin
          mv[mem2proc_tag] = 1'b0;
          if (mo_dm[mem2proc_tag]) dcnt--;
          else icnt--;
        end else merr = 1'b1;
      end
      if (ig && im_command == BUS_LOAD) begin
        mv[mem2proc_response] = 1'b1;
        mo_dm[mem2proc_response] = 1'b0;
        icnt++;
      end
      if (dg && dm_command == BUS_LOAD) begin
        mv[mem2proc_response] = 1'b1;
        mo_dm[mem2proc_response] = 1'b1;
        dcnt++;
      end
    end
  end

  // Drive one cycle's inputs just after the edge, return before the
  // falling edge so literal checks see settled combinational outputs.
  task automatic cyc(input logic [1:0] ic, input logic [31:0] ia,
                     input logic [1:0] dc, input logic [31:0] da,
                     input logic [31:0] dw, input logic [3:0] rsp,
                     input logic [3:0] rt, input logic [31:0] rd);
    @(posedge clk);
    #1;
    im_command = ic; im_addr = ia;
    dm_command = dc; dm_addr = da; dm_wdata = dw;
    mem2proc_response = rsp; mem2proc_tag = rt; mem2proc_data = rd;
    #2;
  endtask

  task automatic idle();
    cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_now_cmd", proc2mem_command, BUS_NONE);
    chk("rst_now_gnt", {im_gnt, dm_gnt}, 0);
    chk("rst_now_rsp", {im_rsp_valid, dm_rsp_valid}, 0);
    chk("rst_now_data", {im_rsp_data, dm_rsp_data}, 0);
    chk("rst_now_err", tag_err, 0);
    im_command = BUS_NONE; dm_command = BUS_NONE;
    mem2proc_response = 0; mem2proc_tag = 0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic logic [3:0] pick_free(input logic [3:0] rt);
    logic [3:0] l[$];
    for (int t = 1; t < 16; t++)
      if (!mv[t] || t == int'(rt)) l.push_back(4'(t));
    if (l.size() == 0) return 4'd0;
    return l[$urandom_range(0, l.size() - 1)];
  endfunction

  function automatic logic [3:0] pick_valid();
    logic [3:0] l[$];
    for (int t = 1; t < 16; t++)
      if (mv[t]) l.push_back(4'(t));
    if (l.size() == 0) return 4'd0;
    return l[$urandom_range(0, l.size() - 1)];
  endfunction

  initial begin
    #2;
    chk("init_cmd", proc2mem_command, BUS_NONE);
    chk("init_err", tag_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Both load: DM wins in reset priority; tag 3 comes back to DM.
    cyc(BUS_LOAD, 32'h100, BUS_LOAD, 32'h200, 0, 3, 0, 0);
    chk("s1_dm_gnt", dm_gnt, 1);
    chk("s1_im_gnt", im_gnt, 0);
    chk("s1_addr", proc2mem_addr, 32'h200);
    cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 3, 32'hDEADBEEF);
    chk("s1_dm_rv", dm_rsp_valid, 1);
    chk("s1_dm_rd", dm_rsp_data, 32'hDEADBEEF);
    chk("s1_im_rv", im_rsp_valid, 0);

    // Starvation: IM wins the 5th contended accepted cycle only.
    for (int i = 1; i <= 6; i++) begin
      cyc(BUS_LOAD, 32'h1000 + i, BUS_LOAD, 32'h2000 + i, 0, 4'(i), 0, 0);
      chk($sformatf("s2_im_gnt%0d", i), im_gnt, i == 5);
      chk($sformatf("s2_dm_gnt%0d", i), dm_gnt, i != 5);
    end
    for (int i = 1; i <= 6; i++)
      cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'(i), 32'(i));

    // Store leaves no entry; its tag coming back is an error.
    cyc(BUS_NONE, 0, BUS_STORE, 32'h40, 32'h55, 2, 0, 0);
    chk("s3_dm_gnt", dm_gnt, 1);
    chk("s3_cmd", proc2mem_command, BUS_STORE);
    chk("s3_data", proc2mem_data, 32'h55);
    cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 2, 32'h1);
    chk("s3_rv", {im_rsp_valid, dm_rsp_valid}, 0);
    idle();
    chk("s3_err", tag_err, 1);

    // IM fills its outstanding budget.
    for (int i = 1; i <= 8; i++) begin
      cyc(BUS_LOAD, 32'h400 + 4 * i, BUS_NONE, 0, 0, 4'(i), 0, 0);
      chk($sformatf("s4_fill%0d", i), im_gnt, 1);
    end
    cyc(BUS_LOAD, 32'h500, BUS_LOAD, 32'h300, 0, 9, 0, 0);
    chk("s4_full_im", im_gnt, 0);
    chk("s4_full_dm", dm_gnt, 1);
    chk("s4_full_addr", proc2mem_addr, 32'h300);
    cyc(BUS_LOAD, 32'h500, BUS_NONE, 0, 0, 0, 1, 32'h11111111);
    chk("s4_ret_rv", im_rsp_valid, 1);
    cyc(BUS_LOAD, 32'h504, BUS_NONE, 0, 0, 10, 0, 0);
    chk("s4_regnt", im_gnt, 1);

    // Tag 5 returns and is reissued to IM in the same cycle.
    cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 2, 32'h2);
    cyc(BUS_LOAD, 32'h600, BUS_NONE, 0, 0, 5, 5, 32'hAAAA5555);
    chk("s5_rv", im_rsp_valid, 1);
    chk("s5_rd", im_rsp_data, 32'hAAAA5555);
    chk("s5_gnt", im_gnt, 1);
    cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 5, 32'h5A5A5A5A);
    chk("s5_again_rv", im_rsp_valid, 1);
    chk("s5_again_dm", dm_rsp_valid, 0);

    // Reset with loads in flight, then a stale return.
    cyc(BUS_LOAD, 32'h700, BUS_LOAD, 32'h704, 0, 12, 3, 32'hFFFFFFFF);
    chk("s6_pre_rv", im_rsp_valid, 1);
    do_reset();
    cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4, 32'h4);
    chk("s6_stale_rv", im_rsp_valid, 0);
    idle();
    chk("s6_stale_err", tag_err, 1);
    do_reset();

    // Randomized traffic, alternating drain-heavy and fill-heavy phases.
    for (int n = 0; n < 2000; n++) begin
      logic [1:0] ic, dc;
      logic [3:0] rt, rsp;
      int r, retp;
      retp = ((n / 250) % 2) != 0 ? 15 : 60;
      ic = ($urandom % 4) != 0 ? BUS_LOAD : BUS_NONE;
      r = int'($urandom % 6);
      dc = r < 2 ? BUS_NONE : r < 5 ? BUS_LOAD : BUS_STORE;
      rt = 0;
      if (int'($urandom % 100) < retp) rt = pick_valid();
      else if ($urandom % 50 == 0) rt = 4'($urandom_range(1, 15));
      rsp = ($urandom % 5 == 0) ? 4'd0 : pick_free(rt);
      cyc(ic, $urandom, dc, $urandom, $urandom, rsp, rt, $urandom);
      if (n == 1000) do_reset();
    end
    idle();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
